// File: rtl/iter_alu.sv
// ============================================================================
// iter_alu : iterative ALU, single-cycle arithmetic/logic, one-bit-per-cycle shifts
// Rev 1.0
// ============================================================================
`default_nettype none

module iter_alu #(
  parameter int reg_width = 9,
  parameter int op_width  = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [reg_width-1:0] ra_in,
  input  logic [reg_width-1:0] rb_in,
  input  logic [op_width-1:0]  op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [reg_width-1:0] res_out,
  output logic [reg_width-1:0] car_out,
  output logic                 zero,
  output logic                 jump
);

  localparam int PAIR_W = 2 * reg_width;
  localparam int CNT_W  = $clog2(PAIR_W + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [op_width-1:0] OP_ADD = op_width'(0);
  localparam logic [op_width-1:0] OP_SUB = op_width'(1);
  localparam logic [op_width-1:0] OP_AND = op_width'(2);
  localparam logic [op_width-1:0] OP_SRL = op_width'(3);
  localparam logic [op_width-1:0] OP_SLL = op_width'(4);
  localparam logic [op_width-1:0] OP_SRA = op_width'(5);
  localparam logic [op_width-1:0] OP_XOR = op_width'(6);
  localparam logic [op_width-1:0] OP_CMP = op_width'(7);

  logic [1:0]           state_q, state_d;
  logic [reg_width-1:0] res_q, res_d;
  logic [reg_width-1:0] car_q, car_d;
  logic                 zero_q, zero_d;
  logic                 jump_q, jump_d;
  logic [op_width-1:0]  op_q, op_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 accept;
  logic                 is_shift;
  logic [CNT_W-1:0]     shift_n;
  logic [reg_width:0]   sum_w;
  logic [reg_width:0]   diff_w;
  logic [PAIR_W-1:0]    pair_shifted;

  assign accept   = (state_q == S_IDLE) && in_valid;
  assign is_shift = (op == OP_SRL) || (op == OP_SLL) || (op == OP_SRA);
  // Shifting by more than the pair width cannot change the result further.
  assign shift_n  = (32'(rb_in) >= PAIR_W) ? CNT_W'(PAIR_W) : CNT_W'(rb_in);
  assign sum_w    = {1'b0, ra_in} + {1'b0, rb_in};
  assign diff_w   = {1'b0, ra_in} - {1'b0, rb_in};

  always_comb begin
    pair_shifted = '0;
    case (op_q)
      OP_SRL:  pair_shifted = {1'b0, res_q, car_q[reg_width-1:1]};
      OP_SRA:  pair_shifted = {res_q[reg_width-1], res_q, car_q[reg_width-1:1]};
      OP_SLL:  pair_shifted = {car_q[reg_width-2:0], res_q, 1'b0};
      default: pair_shifted = {res_q, car_q};
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = (is_shift && shift_n != '0) ? S_SHIFT : S_DONE;
      S_SHIFT: if (cnt_q == CNT_W'(1)) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  always_comb begin
    res_d  = res_q;
    car_d  = car_q;
    zero_d = zero_q;
    jump_d = jump_q;
    op_d   = op_q;
    cnt_d  = cnt_q;
    if (accept) begin
      op_d   = op;
      jump_d = 1'b0;
      car_d  = '0;
      cnt_d  = '0;
      case (op)
        OP_ADD: begin
          res_d = sum_w[reg_width-1:0];
          car_d = reg_width'(sum_w[reg_width]);
        end
        OP_SUB: begin
          res_d = diff_w[reg_width-1:0];
          car_d = reg_width'(diff_w[reg_width]);
        end
        OP_CMP: begin
          res_d  = diff_w[reg_width-1:0];
          car_d  = reg_width'(diff_w[reg_width]);
          jump_d = diff_w[reg_width];
        end
        OP_AND: res_d = ra_in & rb_in;
        OP_XOR: res_d = ra_in ^ rb_in;
        OP_SRL, OP_SLL, OP_SRA: begin
          // Every shift starts from the pair holding ra with an empty carry half.
          res_d = ra_in;
          cnt_d = shift_n;
        end
        default: res_d = '0;
      endcase
      zero_d = (res_d == '0);
    end else if (state_q == S_SHIFT) begin
      if (op_q == OP_SLL) {car_d, res_d} = pair_shifted;
      else                {res_d, car_d} = pair_shifted;
      cnt_d  = cnt_q - CNT_W'(1);
      zero_d = (res_d == '0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_q  <= '0;
      car_q  <= '0;
      zero_q <= 1'b0;
      jump_q <= 1'b0;
      op_q   <= '0;
      cnt_q  <= '0;
    end else begin
      res_q  <= res_d;
      car_q  <= car_d;
      zero_q <= zero_d;
      jump_q <= jump_d;
      op_q   <= op_d;
      cnt_q  <= cnt_d;
    end
  end

  assign res_out = res_q;
  assign car_out = car_q;
  assign zero    = zero_q;
  assign jump    = jump_q;

endmodule

`default_nettype wire
